// File: rtl/fetch_seq_pkg.sv
// Shared constants for the MSP430 fetch sequencer and decoder:
// instruction formats, FSM state encoding, RETI and constant-generator registers.
package fetch_seq_pkg;

    localparam logic [1:0] FMT_ILL = 2'd0;
    localparam logic [1:0] FMT_I   = 2'd1;
    localparam logic [1:0] FMT_II  = 2'd2;
    localparam logic [1:0] FMT_J   = 2'd3;

    localparam logic [15:0] RETI_OP = 16'h1300;

    localparam logic [3:0] CG_R2 = 4'd2;
    localparam logic [3:0] CG_R3 = 4'd3;

    typedef enum logic [2:0] {
        S_WAIT,
        S_FETCH_OP,
        S_FETCH_SRC,
        S_FETCH_DST,
        S_ISSUE
    } state_t;

endpackage

// File: rtl/fetch_seq_if.sv
// ROM-side and execute-side bundle of the fetch sequencer.
// master = sequencer, slave = ROM/execute environment.
interface fetch_seq_if #(
    parameter int DW = 16
);
    logic [DW-1:0] MDB_out;
    logic          mem_ready;
    logic          rd_en;
    logic          pc_inc;
    logic          ex_ready;
    logic          instr_valid;
    logic [DW-1:0] opcode;
    logic [DW-1:0] ext_src;
    logic [DW-1:0] ext_dst;
    logic [1:0]    n_ext;
    logic [1:0]    FORMAT;
    logic          illegal;

    modport master (
        input  MDB_out, mem_ready, ex_ready,
        output rd_en, pc_inc, instr_valid, opcode,
        output ext_src, ext_dst, n_ext, FORMAT, illegal
    );

    modport slave (
        output MDB_out, mem_ready, ex_ready,
        input  rd_en, pc_inc, instr_valid, opcode,
        input  ext_src, ext_dst, n_ext, FORMAT, illegal
    );
endinterface

// File: rtl/fetch_seq_ext_word_count.sv
// Opcode classifier: instruction format, illegal flag and which
// extension words follow. Purely combinational, shared with the decoder.
module fetch_seq_ext_word_count
    import fetch_seq_pkg::*;
(
    input  logic [15:0] op,
    output logic        need_src,
    output logic        need_dst,
    output logic [1:0]  fmt,
    output logic        illegal
);

    logic [3:0] msb;
    logic [3:0] r;
    logic [1:0] as_m;
    logic       cg;
    logic       reti;

    always_comb begin
        msb = op[15:12];
        fmt = FMT_ILL;
        unique case (1'b1)
            (msb >= 4'd4):                fmt = FMT_I;
            (msb == 4'd1):                fmt = FMT_II;
            (msb == 4'd2 || msb == 4'd3): fmt = FMT_J;
            default:                      fmt = FMT_ILL;
        endcase

        r    = (fmt == FMT_I) ? op[11:8] : op[3:0];
        as_m = op[5:4];
        // R3 always and R2 with As=1x synthesize constants in-core
        cg   = (r == CG_R3) || (r == CG_R2 && as_m[1]);
        reti = (op == RETI_OP);

        need_src = (fmt == FMT_I || fmt == FMT_II) && !reti && !cg &&
                   ((as_m == 2'b01) || (as_m == 2'b11 && r == 4'd0));
        need_dst = (fmt == FMT_I) && op[7];
        illegal  = (fmt == FMT_ILL);
    end

endmodule

// File: rtl/fetch_seq.sv
// MSP430 fetch sequencer: opcode + 0..2 extension words, then issue.
// FETCH_SEQ_ICOUNT_EN adds the issued-instruction counter.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter int RST_VEC_WAIT = 1,
    parameter int DW           = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    output logic [15:0] instr_count,
    fetch_seq_if.master bus
);

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    wait_cnt;

    logic [DW-1:0] opcode_q;
    logic [DW-1:0] ext_src_q;
    logic [DW-1:0] ext_dst_q;
    logic [1:0]    n_ext_q;
    logic [1:0]    fmt_q;
    logic          illegal_q;
    logic          need_dst_q;

    logic          need_src_c;
    logic          need_dst_c;
    logic [1:0]    fmt_c;
    logic          illegal_c;
    logic          capture;

    fetch_seq_ext_word_count u_ewc (
        .op       (bus.MDB_out),
        .need_src (need_src_c),
        .need_dst (need_dst_c),
        .fmt      (fmt_c),
        .illegal  (illegal_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_WAIT;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= 2'(RST_VEC_WAIT);
        else if (state == S_WAIT && wait_cnt != 2'd0)
            wait_cnt <= wait_cnt - 2'd1;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_WAIT:
                if (wait_cnt <= 2'd1) state_nxt = S_FETCH_OP;
            S_FETCH_OP:
                if (bus.mem_ready) begin
                    if (need_src_c)      state_nxt = S_FETCH_SRC;
                    else if (need_dst_c) state_nxt = S_FETCH_DST;
                    else                 state_nxt = S_ISSUE;
                end
            S_FETCH_SRC:
                if (bus.mem_ready)
                    state_nxt = need_dst_q ? S_FETCH_DST : S_ISSUE;
            S_FETCH_DST:
                if (bus.mem_ready) state_nxt = S_ISSUE;
            S_ISSUE:
                if (bus.ex_ready) state_nxt = S_FETCH_OP;
            default:
                state_nxt = S_WAIT;
        endcase
        if (flush && state != S_WAIT) state_nxt = S_FETCH_OP;
    end

    // flush suppresses both the fetch and the issue of its cycle
    always_comb begin
        bus.rd_en       = 1'b0;
        bus.instr_valid = 1'b0;
        unique case (state)
            S_FETCH_OP,
            S_FETCH_SRC,
            S_FETCH_DST: bus.rd_en       = !flush;
            S_ISSUE:     bus.instr_valid = !flush;
            default: ;
        endcase
        capture    = bus.rd_en && bus.mem_ready && !rst;
        bus.pc_inc = capture;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            opcode_q   <= '0;
            ext_src_q  <= '0;
            ext_dst_q  <= '0;
            n_ext_q    <= 2'd0;
            fmt_q      <= FMT_ILL;
            illegal_q  <= 1'b0;
            need_dst_q <= 1'b0;
        end else if (capture) begin
            unique case (state)
                S_FETCH_OP: begin
                    opcode_q   <= bus.MDB_out;
                    ext_src_q  <= '0;
                    ext_dst_q  <= '0;
                    n_ext_q    <= 2'd0;
                    fmt_q      <= fmt_c;
                    illegal_q  <= illegal_c;
                    need_dst_q <= need_dst_c;
                end
                S_FETCH_SRC: begin
                    ext_src_q <= bus.MDB_out;
                    n_ext_q   <= n_ext_q + 2'd1;
                end
                S_FETCH_DST: begin
                    ext_dst_q <= bus.MDB_out;
                    n_ext_q   <= n_ext_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.opcode  = opcode_q;
    assign bus.ext_src = ext_src_q;
    assign bus.ext_dst = ext_dst_q;
    assign bus.n_ext   = n_ext_q;
    assign bus.FORMAT  = fmt_q;
    assign bus.illegal = illegal_q;

`ifdef FETCH_SEQ_ICOUNT_EN
    logic        accept;
    logic [15:0] icnt_q;

    assign accept = bus.instr_valid && bus.ex_ready && !rst;

    always_ff @(posedge clk) begin
        if (rst)         icnt_q <= 16'd0;
        else if (accept) icnt_q <= icnt_q + 16'd1;
    end

    assign instr_count = icnt_q;
`else
    assign instr_count = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: ROM model with wait states,
// expected instructions queued at load and checked at issue.
module tb_fetch_seq;

    typedef struct {
        logic [15:0] op;
        logic [15:0] src;
        logic [15:0] dst;
        logic [1:0]  n;
        logic [1:0]  fmt;
        logic        ill;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] instr_count;

    fetch_seq_if bus ();

    fetch_seq #(
        .RST_VEC_WAIT (1),
        .DW           (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .instr_count (instr_count),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    logic [15:0] rom_q[$];
    int          stall;
    int          wait_words;
    int          pulses;
    int          cap_cyc;
    int          cyc;
    int          acc_exp;
    int          n_chk;
    int          n_err;
    bit          prev_valid;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic drive_rom();
        bus.mem_ready = (rom_q.size() > 0) && (stall == 0);
        bus.MDB_out   = bus.mem_ready ? rom_q[0] : 16'hBAD0;
    endtask

    task automatic load(input int n, input logic [15:0] w0,
                        input logic [15:0] w1, input logic [15:0] w2,
                        input int w);
        if (rom_q.size() == 0) stall = w;
        wait_words = w;
        rom_q.push_back(w0);
        if (n > 1) rom_q.push_back(w1);
        if (n > 2) rom_q.push_back(w2);
        drive_rom();
    endtask

    task automatic push_exp(input logic [15:0] op, input logic [15:0] src,
                            input logic [15:0] dst, input logic [1:0] n,
                            input logic [1:0] fmt, input logic ill,
                            input int lat);
        exp_t e;
        e.op  = op;
        e.src = src;
        e.dst = dst;
        e.n   = n;
        e.fmt = fmt;
        e.ill = ill;
        e.lat = lat;
        exp_q.push_back(e);
        acc_exp++;
    endtask

    task automatic tick();
        exp_t e;
        logic take;
        logic req;
        @(negedge clk);
        take = bus.pc_inc;
        req  = bus.rd_en;
        if (take === 1'b1) begin
            chk("pcinc_ready", bus.mem_ready, 1);
            if (pulses == 0) cap_cyc = cyc;
            pulses++;
        end
        if (bus.instr_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", bus.opcode, 32'hFFFF_FFFF);
            end else begin
                e = exp_q[0];
                chk("rd_in_issue", bus.rd_en, 0);
                if (!prev_valid) chk("latency", cyc - cap_cyc, e.lat);
                chk("opcode", bus.opcode, e.op);
                chk("ext_src", bus.ext_src, e.src);
                chk("ext_dst", bus.ext_dst, e.dst);
                chk("n_ext", bus.n_ext, e.n);
                chk("format", bus.FORMAT, e.fmt);
                chk("illegal", bus.illegal, e.ill);
                if (bus.ex_ready === 1'b1) begin
                    chk("pc_pulses", pulses, 1 + e.n);
                    pulses = 0;
                    void'(exp_q.pop_front());
                end
            end
        end
        prev_valid = (bus.instr_valid === 1'b1);
        @(posedge clk);
        #1;
        cyc++;
        if (take === 1'b1 && rom_q.size() > 0) begin
            void'(rom_q.pop_front());
            stall = wait_words;
        end else if (req === 1'b1 && stall > 0) begin
            stall--;
        end
        drive_rom();
    endtask

    task automatic run_all();
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic wait_pulses(input int n);
        for (int i = 0; i < 60 && pulses < n; i++) tick();
        chk("reach_pulses", pulses, n);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 60 && !prev_valid; i++) tick();
        chk("reach_valid", prev_valid, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {bus.rd_en, bus.pc_inc, bus.instr_valid, bus.illegal,
                  bus.FORMAT, bus.n_ext, instr_count}, 0);
        chk({tag, "_op_src"}, {bus.opcode, bus.ext_src}, 0);
        chk({tag, "_dst"}, bus.ext_dst, 0);
    endtask

    task automatic chk_icnt();
`ifdef FETCH_SEQ_ICOUNT_EN
        chk("icount", instr_count, acc_exp);
`else
        chk("icount", instr_count, 0);
`endif
    endtask

    initial begin
        n_chk = 0; n_err = 0; cyc = 0; pulses = 0; cap_cyc = 0;
        stall = 0; wait_words = 0; acc_exp = 0; prev_valid = 0;
        rst = 1'b1;
        flush = 1'b0;
        bus.ex_ready = 1'b1;
        drive_rom();
        tick();
        tick();
        chk_zero("rst_state");

        rst = 1'b0;
        #1;
        chk("wait_idle", bus.rd_en, 0);
        tick();
        chk("first_fetch", bus.rd_en, 1);

        load(1, 16'h4405, 16'h0, 16'h0, 0);
        push_exp(16'h4405, 16'h0, 16'h0, 2'd0, 2'd1, 1'b0, 1);
        run_all();

        load(3, 16'h40B2, 16'h1234, 16'h0200, 0);
        push_exp(16'h40B2, 16'h1234, 16'h0200, 2'd2, 2'd1, 1'b0, 3);
        run_all();

        load(2, 16'h3C05, 16'h4325, 16'h0, 0);
        push_exp(16'h3C05, 16'h0, 16'h0, 2'd0, 2'd3, 1'b0, 1);
        push_exp(16'h4325, 16'h0, 16'h0, 2'd0, 2'd1, 1'b0, 1);
        run_all();

        load(3, 16'h4592, 16'h0004, 16'h0006, 2);
        push_exp(16'h4592, 16'h0004, 16'h0006, 2'd2, 2'd1, 1'b0, 7);
        run_all();
        chk_icnt();

        bus.ex_ready = 1'b0;
        load(1, 16'h1085, 16'h0, 16'h0, 0);
        push_exp(16'h1085, 16'h0, 16'h0, 2'd0, 2'd2, 1'b0, 1);
        wait_valid();
        repeat (5) tick();
        bus.ex_ready = 1'b1;
        run_all();

        load(3, 16'h40B2, 16'h1111, 16'h2222, 3);
        wait_pulses(1);
        tick();
        flush = 1'b1;
        stall = 0;
        drive_rom();
        #1;
        chk("flush_src_pcinc", bus.pc_inc, 0);
        chk("flush_src_valid", bus.instr_valid, 0);
        tick();
        flush = 1'b0;
        rom_q.delete();
        stall = 0;
        pulses = 0;
        drive_rom();
        #1;
        chk("flush_clr", {bus.opcode, bus.ext_src}, 0);
        chk("flush_clr_n", {bus.n_ext, bus.FORMAT}, 0);
        chk("flush_refetch", bus.rd_en, 1);

        bus.ex_ready = 1'b0;
        load(2, 16'h1290, 16'h0042, 16'h0, 0);
        push_exp(16'h1290, 16'h0042, 16'h0, 2'd1, 2'd2, 1'b0, 2);
        wait_valid();
        tick();
        flush = 1'b1;
        bus.ex_ready = 1'b1;
        #1;
        chk("flush_issue_valid", bus.instr_valid, 0);
        tick();
        flush = 1'b0;
        void'(exp_q.pop_front());
        acc_exp--;
        pulses = 0;
        chk_icnt();

        load(3, 16'h1290, 16'h0077, 16'h1300, 0);
        push_exp(16'h1290, 16'h0077, 16'h0, 2'd1, 2'd2, 1'b0, 2);
        push_exp(16'h1300, 16'h0, 16'h0, 2'd0, 2'd2, 1'b0, 1);
        run_all();
        chk_icnt();

        load(3, 16'h40B2, 16'h1234, 16'h0200, 2);
        wait_pulses(2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rom_q.delete();
        stall = 0;
        pulses = 0;
        acc_exp = 0;
        drive_rom();
        #1;
        chk_zero("rst_mid_dst");
        tick();
        chk("refetch_after_rst", bus.rd_en, 1);

        load(1, 16'h0000, 16'h0, 16'h0, 0);
        push_exp(16'h0000, 16'h0, 16'h0, 2'd0, 2'd0, 1'b1, 1);
        run_all();
        chk_icnt();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
